// File: rtl/crc5_d11_checker_if.sv
// Bundles the serial-bit inputs and the result outputs of crc5_d11_checker.
// err_count exists only when CRC5_CHK_STATS_EN is defined.
interface crc5_d11_checker_if;
  logic        sop;
  logic        bit_valid;
  logic        bit_in;
  logic [10:0] data_out;
  logic        crc_ok;
  logic        crc_err;
  logic        busy;
`ifdef CRC5_CHK_STATS_EN
  logic [7:0]  err_count;

  modport master (
    output sop, bit_valid, bit_in,
    input  data_out, crc_ok, crc_err, busy, err_count
  );

  modport slave (
    input  sop, bit_valid, bit_in,
    output data_out, crc_ok, crc_err, busy, err_count
  );
`else
  modport master (
    output sop, bit_valid, bit_in,
    input  data_out, crc_ok, crc_err, busy
  );

  modport slave (
    input  sop, bit_valid, bit_in,
    output data_out, crc_ok, crc_err, busy
  );
`endif
endinterface

// File: rtl/crc5_d11_checker.sv
// Serial CRC5 (x^5+x^2+1, seed 5'h1F) checker for 11-bit data tokens.
// Define CRC5_CHK_STATS_EN to add the saturating err_count mismatch counter.
module crc5_d11_checker (
  input  logic                clk,
  input  logic                reset_L,
  crc5_d11_checker_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StData, StCrc, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  crc_q, crc_d;
  logic [10:0] data_sr_q, data_sr_d;
  logic [4:0]  rx_crc_q, rx_crc_d;
  logic [10:0] data_out_q, data_out_d;
  logic        crc_ok_q, crc_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        busy_q, busy_d;

  function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = b ^ c[4];
    return {c[3], c[2], c[1] ^ fb, c[0], fb};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    data_sr_d  = data_sr_q;
    rx_crc_d   = rx_crc_q;
    data_out_d = data_out_q;
    crc_ok_d   = 1'b0;
    crc_err_d  = 1'b0;

    // sop restarts from any state; a bit in the sop cycle is d[10]
    if (bus.sop) begin
      state_d   = StData;
      rx_crc_d  = '0;
      if (bus.bit_valid) begin
        crc_d     = crc_step(5'h1F, bus.bit_in);
        data_sr_d = {10'd0, bus.bit_in};
        cnt_d     = 4'd1;
      end else begin
        crc_d     = 5'h1F;
        data_sr_d = '0;
        cnt_d     = 4'd0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StData: begin
          if (bus.bit_valid) begin
            data_sr_d = {data_sr_q[9:0], bus.bit_in};
            crc_d     = crc_step(crc_q, bus.bit_in);
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == 4'd10) state_d = StCrc;
          end
        end
        StCrc: begin
          if (bus.bit_valid) begin
            rx_crc_d = {rx_crc_q[3:0], bus.bit_in};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d    = StDone;
              data_out_d = data_sr_q;
              crc_ok_d   = (rx_crc_d == crc_q);
              crc_err_d  = (rx_crc_d != crc_q);
            end
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StData) || (state_d == StCrc);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      crc_q      <= '0;
      data_sr_q  <= '0;
      rx_crc_q   <= '0;
      data_out_q <= '0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      data_sr_q  <= data_sr_d;
      rx_crc_q   <= rx_crc_d;
      data_out_q <= data_out_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.crc_ok   = crc_ok_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.busy     = busy_q;

`ifdef CRC5_CHK_STATS_EN
  logic [7:0] err_count_q, err_count_d;

  // Counted on the same edge that raises crc_err, so it is visible with the pulse
  always_comb begin
    err_count_d = err_count_q;
    if (crc_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) err_count_q <= '0;
    else          err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: doc/crc5_d11_checker.md
# crc5_d11_checker

Serial receive-side checker for the 11-bit-data / CRC5 token format (polynomial x^5 + x^2 + 1, seed 5'h1F) produced by the team's parallel CRC5 generator. It sits after bit de-stuffing in the receive path. It shifts in 16 bits (11 data bits, then 5 CRC bits), recomputes CRC5 bit-serially over the data, and compares the result with the received field. It then emits the recovered data word with a one-cycle OK or ERROR strobe.

## Interface
- No parameters. Width (11 data + 5 CRC) and seed (5'h1F) are fixed.
- clk  in  1  rising-edge clock
- reset_L  in  1  asynchronous, active-low reset
- sop  in  1  start-of-packet strobe; clears the running state and arms reception
- bit_valid  in  1  bit_in is valid this cycle
- bit_in  in  1  serial bit: d[10] first … d[0], then crc[4] first … crc[0]
- data_out  out  11  last completed data word; held until the next completion
- crc_ok  out  1  one-cycle pulse: packet complete, CRC matched
- crc_err  out  1  one-cycle pulse: packet complete, CRC mismatched
- busy  out  1  high while in DATA or CRC state
- err_count  out  8  saturating mismatch counter; only present with CRC5_CHK_STATS_EN

## Operation
- **Running CRC c[4:0], per accepted data bit b:**
  - fb = b ^ c[4]
  - c <= {c[3], c[2], c[1]^fb, c[0], fb}
  - This matches the team's parallel generator applied to d[10:0] with d[10] consumed first.
- **FSM states:** IDLE, DATA, CRC, DONE. The bit counter cnt is 4 bits.
- **IDLE:**
  - Bits are ignored.
  - sop sets c=5'h1F, cnt=0 and moves to DATA.
  - If bit_valid is high in the sop cycle, that bit is accepted as d[10] and cnt=1.
- **DATA:**
  - Each bit_valid shifts bit_in into the data shift register (LSB in), updates c, and increments cnt.
  - The 11th accepted bit moves to CRC.
- **CRC:**
  - Each bit_valid shifts bit_in into rx_crc (LSB in) and increments cnt. c is frozen.
  - The 16th accepted bit moves to DONE.
- **DONE (exactly one cycle):**
  - data_out <= data shift register.
  - crc_ok = (rx_crc == c); crc_err = !crc_ok.
  - Then IDLE. A bit_valid arriving in the DONE cycle is ignored.
- **sop in DATA, CRC or DONE:**
  - Aborts silently: no ok/err pulse, data_out unchanged, restart exactly as from IDLE.
  - sop in DONE still issues that cycle's pulse, then the packet restarts.
- **Gaps:** bit_valid gaps of any length are allowed; no timeout.
- **busy:** 1 in DATA and CRC; 0 in IDLE and DONE.
- **Reset:** state IDLE, c=0, cnt=0, shift registers 0, data_out=0, crc_ok=0, crc_err=0, busy=0, err_count=0.

## Timing
- All outputs are registered.
- crc_ok/crc_err assert in the cycle after the clock edge that accepts the 16th bit and last exactly one cycle. data_out updates on that same edge.
- Minimum packet time is 16 cycles of bit acceptance plus 1 DONE cycle. Back-to-back: sop may be asserted in the DONE cycle.
- crc_ok and crc_err are never high together.
- Asserting reset_L low mid-packet clears everything immediately (asynchronously); no pulse is emitted.

## Configuration
- **CRC5_CHK_STATS_EN defined:**
  - Adds the err_count[7:0] port.
  - err_count increments on each crc_err pulse and saturates at 8'hFF.
  - sop does not clear it; only reset_L does.
- **CRC5_CHK_STATS_EN undefined:** the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- **Good packet, all-zero data:** reset, sop + 16 contiguous bits: d=11'h000, then crc=5'b10111 → crc_ok pulse one cycle after the 16th bit, data_out=11'h000, crc_err=0.
- **Corrupted CRC:** same packet with crc=5'b10110 → crc_err single pulse, crc_ok=0, data_out=11'h000, err_count=1 (stats build).
- **Gapped input:** same good packet with bit_valid low for 3 cycles between every bit → crc_ok pulse, busy high from after sop until DONE.
- **Abort on sop:** sop, 7 bits, then sop + the full good packet → exactly one crc_ok and no earlier pulse. Then cross-check randomised data/CRC pairs against the parallel generator model: ok iff the CRC field equals the generator output with seed 5'h1F.
- **Reset mid-packet:** reset_L low after bit 12 → all outputs 0 at once. A following good packet yields crc_ok.
- **Counter saturation (stats build):** 256 bad packets → err_count holds at 8'hFF. A good packet does not change it.
